// File: rtl/w_order_scheduler.sv
// rtl/w_order_scheduler.sv - W-data bus sequencer: AW order queue, burst routing, WLAST check
module w_order_scheduler #(
  parameter int N     = 2,
  parameter int M     = 2,
  parameter int DEPTH = 4,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1,
  parameter int LOG_M = (M > 1) ? $clog2(M) : 1,
  parameter int LOG_D = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aw_fire_i,
  input  logic [LOG_N-1:0] aw_src_i,
  input  logic [LOG_M-1:0] aw_dst_i,
  input  logic [7:0]       aw_len_i,
  output logic             aw_full_o,
  input  logic [N-1:0]     s_wvalid_i,
  input  logic [N-1:0]     s_wlast_i,
  output logic [N-1:0]     s_wready_o,
  output logic [LOG_N-1:0] w_sel_o,
  output logic [M-1:0]     w_dst_vld_o,
  input  logic [M-1:0]     w_dst_rdy_i,
  output logic [LOG_D:0]   occ_o,
  output logic             err_o
);

  localparam int OCC_W = LOG_D + 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // Order queue storage: one entry per accepted AW, oldest at r_rptr
  logic [LOG_N-1:0] r_src [DEPTH];
  logic [LOG_M-1:0] r_dst [DEPTH];
  logic [7:0]       r_len [DEPTH];

  logic [LOG_D-1:0] r_wptr;
  logic [LOG_D-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [7:0]       r_cnt;
  logic             r_err;
  logic             r_full;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [LOG_N-1:0] w_head_src;
  logic [LOG_M-1:0] w_head_dst;
  logic [7:0]       w_head_len;
  logic             w_burst;
  logic             w_src_vld;
  logic             w_dst_rdy;
  logic             w_hs;
  logic             w_at_len;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_wlast_err;
  logic [OCC_W-1:0] w_occ_nxt;

  assign w_head_src  = r_src[r_rptr];
  assign w_head_dst  = r_dst[r_rptr];
  assign w_head_len  = r_len[r_rptr];
  assign w_burst     = (r_state == S_BURST);
  assign w_src_vld   = s_wvalid_i[w_head_src];
  assign w_dst_rdy   = w_dst_rdy_i[w_head_dst];
  assign w_hs        = w_burst & w_src_vld & w_dst_rdy;
  assign w_at_len    = (r_cnt == w_head_len);
  // The beat counter, not WLAST, decides where a burst ends
  assign w_pop       = w_hs & w_at_len;
  assign w_push      = aw_fire_i & (r_occ != FULL_LVL);
  assign w_drop      = aw_fire_i & (r_occ == FULL_LVL);
  assign w_wlast_err = w_hs & (s_wlast_i[w_head_src] != w_at_len);

  assign aw_full_o = r_full;
  assign occ_o     = r_occ;
  assign err_o     = r_err;

  // Next occupancy: a simultaneous push and pop cancel out
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // FSM next state and routing outputs, all derived from the registered head entry
  always_comb begin
    w_state_nxt = r_state;
    w_sel_o     = '0;
    w_dst_vld_o = '0;
    s_wready_o  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_occ_nxt != '0) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        w_sel_o = w_head_src;
        for (int d = 0; d < M; d++) begin
          w_dst_vld_o[d] = w_src_vld & (w_head_dst == LOG_M'(d));
        end
        for (int i = 0; i < N; i++) begin
          s_wready_o[i] = (w_head_src == LOG_N'(i)) & w_dst_rdy;
        end
        if (w_occ_nxt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: pointers, occupancy, beat counter, sticky error, FSM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
      r_full  <= (w_occ_nxt == FULL_LVL);
      if (w_push) r_wptr <= r_wptr + LOG_D'(1);
      if (w_pop)  r_rptr <= r_rptr + LOG_D'(1);
      if (w_pop)      r_cnt <= '0;
      else if (w_hs)  r_cnt <= r_cnt + 8'd1;
      if (w_drop || w_wlast_err) r_err <= 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy alone says which entries are live
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_src[r_wptr] <= aw_src_i;
      r_dst[r_wptr] <= aw_dst_i;
      r_len[r_wptr] <= aw_len_i;
    end
  end

endmodule

// File: tb/tb_w_order_scheduler.sv
// tb/tb_w_order_scheduler.sv - scoreboard bench for w_order_scheduler
module tb_w_order_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       aw_fire_i = 1'b0;
  logic       aw_src_i = 1'b0;
  logic       aw_dst_i = 1'b0;
  logic [7:0] aw_len_i = 8'd0;
  logic       aw_full_o;
  logic [1:0] s_wvalid_i = 2'b00;
  logic [1:0] s_wlast_i = 2'b00;
  logic [1:0] s_wready_o;
  logic       w_sel_o;
  logic [1:0] w_dst_vld_o;
  logic [1:0] w_dst_rdy_i = 2'b00;
  logic [2:0] occ_o;
  logic       err_o;

  typedef struct packed {
    logic       sel;
    logic [1:0] vld;
    logic [1:0] rdy;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int n_checks = 0;
  int n_errors = 0;

  w_order_scheduler #(.N(2), .M(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .aw_fire_i(aw_fire_i), .aw_src_i(aw_src_i), .aw_dst_i(aw_dst_i), .aw_len_i(aw_len_i),
    .aw_full_o(aw_full_o),
    .s_wvalid_i(s_wvalid_i), .s_wlast_i(s_wlast_i), .s_wready_o(s_wready_o),
    .w_sel_o(w_sel_o), .w_dst_vld_o(w_dst_vld_o), .w_dst_rdy_i(w_dst_rdy_i),
    .occ_o(occ_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input logic s, input logic d);
    beat_t b;
    b.sel = s;
    b.vld = 2'(2'b01 << d);
    b.rdy = 2'(2'b01 << s);
    exp_q.push_back(b);
  endtask

  task automatic aw(input logic s, input logic d, input logic [7:0] l);
    aw_fire_i = 1'b1;
    aw_src_i  = s;
    aw_dst_i  = d;
    aw_len_i  = l;
    step();
    aw_fire_i = 1'b0;
  endtask

  task automatic pulse_rst();
    s_wvalid_i = 2'b00;
    s_wlast_i  = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Monitor: every beat handshake the DUT presents must match the next expected beat
  always @(negedge clk) begin
    if (!rst && (|(w_dst_vld_o & w_dst_rdy_i))) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_b = exp_q.pop_front();
        chk("beat_sel", 32'(w_sel_o), 32'(mon_b.sel));
        chk("beat_dst_vld", 32'(w_dst_vld_o), 32'(mon_b.vld));
        chk("beat_wready", 32'(s_wready_o), 32'(mon_b.rdy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_occ", 32'(occ_o), 0);
    chk("rst_full", 32'(aw_full_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_wready", 32'(s_wready_o), 0);
    chk("rst_vld", 32'(w_dst_vld_o), 0);
    chk("rst_sel", 32'(w_sel_o), 0);
    step();
    rst = 1'b0;
    step();

    // 1: single 4-beat burst from m1 to s0
    aw(1'b1, 1'b0, 8'd3);
    chk("t1_occ_after_aw", 32'(occ_o), 1);
    w_dst_rdy_i = 2'b11;
    s_wvalid_i  = 2'b10;
    for (int b = 0; b < 4; b++) begin
      s_wlast_i = (b == 3) ? 2'b10 : 2'b00;
      exp_beat(1'b1, 1'b0);
      step();
    end
    s_wvalid_i = 2'b00;
    s_wlast_i  = 2'b00;
    chk("t1_occ_end", 32'(occ_o), 0);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // 2: back-to-back AWs, zero bubble between bursts
    aw_fire_i = 1'b1; aw_src_i = 1'b0; aw_dst_i = 1'b1; aw_len_i = 8'd0;
    step();
    aw_src_i = 1'b1; aw_dst_i = 1'b0; aw_len_i = 8'd1;
    s_wvalid_i = 2'b11;
    s_wlast_i  = 2'b01;
    exp_beat(1'b0, 1'b1);
    #1;
    chk("t2_m1_wready_low", 32'(s_wready_o), 32'b01);
    step();
    aw_fire_i = 1'b0;
    s_wvalid_i = 2'b10;
    s_wlast_i  = 2'b00;
    exp_beat(1'b1, 1'b0);
    step();
    s_wlast_i = 2'b10;
    exp_beat(1'b1, 1'b0);
    step();
    s_wvalid_i = 2'b00;
    s_wlast_i  = 2'b00;
    chk("t2_occ_end", 32'(occ_o), 0);
    chk("t2_q_empty", 32'(exp_q.size()), 0);

    // 3: fill, overflow drop, push+pop at occ=3
    aw(1'b0, 1'b0, 8'd0);
    aw(1'b1, 1'b1, 8'd0);
    aw(1'b0, 1'b1, 8'd0);
    aw(1'b1, 1'b0, 8'd0);
    chk("t3_occ_full", 32'(occ_o), 4);
    chk("t3_full", 32'(aw_full_o), 1);
    chk("t3_err_before", 32'(err_o), 0);
    aw(1'b1, 1'b1, 8'd5);
    chk("t3_occ_after_drop", 32'(occ_o), 4);
    chk("t3_err_drop", 32'(err_o), 1);
    s_wvalid_i = 2'b01; s_wlast_i = 2'b01;
    exp_beat(1'b0, 1'b0);
    step();
    s_wvalid_i = 2'b00; s_wlast_i = 2'b00;
    chk("t3_occ_3", 32'(occ_o), 3);
    chk("t3_not_full", 32'(aw_full_o), 0);
    s_wvalid_i = 2'b10; s_wlast_i = 2'b10;
    exp_beat(1'b1, 1'b1);
    aw(1'b0, 1'b0, 8'd1);
    chk("t3_occ_push_pop", 32'(occ_o), 3);
    s_wvalid_i = 2'b01; s_wlast_i = 2'b01; exp_beat(1'b0, 1'b1); step();
    s_wvalid_i = 2'b10; s_wlast_i = 2'b10; exp_beat(1'b1, 1'b0); step();
    s_wvalid_i = 2'b01; s_wlast_i = 2'b00; exp_beat(1'b0, 1'b0); step();
    s_wlast_i = 2'b01; exp_beat(1'b0, 1'b0); step();
    s_wvalid_i = 2'b00; s_wlast_i = 2'b00;
    chk("t3_occ_end", 32'(occ_o), 0);
    chk("t3_q_empty", 32'(exp_q.size()), 0);
    pulse_rst();
    chk("t3_err_cleared", 32'(err_o), 0);

    // 4: early WLAST sets sticky error, burst still ends at len
    aw(1'b0, 1'b1, 8'd3);
    s_wvalid_i = 2'b01;
    s_wlast_i = 2'b00; exp_beat(1'b0, 1'b1); step();
    chk("t4_err_b0", 32'(err_o), 0);
    s_wlast_i = 2'b01; exp_beat(1'b0, 1'b1); step();
    chk("t4_err_set", 32'(err_o), 1);
    s_wlast_i = 2'b00; exp_beat(1'b0, 1'b1); step();
    chk("t4_occ_mid", 32'(occ_o), 1);
    chk("t4_err_sticky", 32'(err_o), 1);
    s_wlast_i = 2'b01; exp_beat(1'b0, 1'b1); step();
    s_wvalid_i = 2'b00; s_wlast_i = 2'b00;
    chk("t4_occ_end", 32'(occ_o), 0);
    chk("t4_err_end", 32'(err_o), 1);
    pulse_rst();

    // 5: backpressure mid-burst holds the beat counter
    aw(1'b1, 1'b1, 8'd7);
    s_wvalid_i = 2'b10;
    s_wlast_i  = 2'b00;
    for (int b = 0; b < 2; b++) begin
      exp_beat(1'b1, 1'b1);
      step();
    end
    w_dst_rdy_i = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_stall_wready", 32'(s_wready_o), 0);
      chk("t5_stall_vld", 32'(w_dst_vld_o), 32'b10);
      step();
    end
    w_dst_rdy_i = 2'b11;
    for (int b = 2; b < 8; b++) begin
      s_wlast_i = (b == 7) ? 2'b10 : 2'b00;
      exp_beat(1'b1, 1'b1);
      if (b == 7) chk("t5_occ_before_last", 32'(occ_o), 1);
      step();
    end
    s_wvalid_i = 2'b00; s_wlast_i = 2'b00;
    chk("t5_occ_end", 32'(occ_o), 0);
    chk("t5_err", 32'(err_o), 0);

    // 6: reset mid-burst discards queue and partial count
    aw(1'b0, 1'b0, 8'd3);
    aw(1'b1, 1'b1, 8'd0);
    chk("t6_occ_2", 32'(occ_o), 2);
    s_wvalid_i = 2'b01; s_wlast_i = 2'b01;
    exp_beat(1'b0, 1'b0);
    step();
    chk("t6_err_pre", 32'(err_o), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_occ", 32'(occ_o), 0);
    chk("t6_rst_vld", 32'(w_dst_vld_o), 0);
    chk("t6_rst_wready", 32'(s_wready_o), 0);
    chk("t6_rst_err", 32'(err_o), 0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_post_vld", 32'(w_dst_vld_o), 0);
    chk("t6_post_occ", 32'(occ_o), 0);
    s_wvalid_i = 2'b00; s_wlast_i = 2'b00;
    step();
    aw(1'b1, 1'b0, 8'd0);
    s_wvalid_i = 2'b10; s_wlast_i = 2'b10;
    exp_beat(1'b1, 1'b0);
    step();
    s_wvalid_i = 2'b00; s_wlast_i = 2'b00;
    chk("t6_occ_end", 32'(occ_o), 0);
    chk("t6_err_end", 32'(err_o), 0);
    chk("t6_q_empty", 32'(exp_q.size()), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
